oam_dma: RTL

OAM DMA controller and CPU bus gate, placed directly downstream of `cpu` on the system bus.
- Intercepts CPU accesses to the DMA register at 0xFF46.
- On a write to 0xFF46, copies 160 bytes from `{src_hi, 8'h00}` into OAM, one byte per M-cycle, through a dedicated OAM write port.
- While a transfer is active, blocks CPU accesses below 0xFF00. Accesses to 0xFF00–0xFFFF (IO and HRAM) are forwarded.

---
 rtl/oam_dma.sv | 127 ++++++++++++
 1 files changed

// File: rtl/oam_dma.sv
// OAM DMA controller sitting between the CPU and the system bus.
// Copies 160 bytes into OAM on a write to 0xFF46 and gates CPU access below 0xFF00 meanwhile.
module oam_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_enable,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic [15:0] bus_addr,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  oam_addr,
    output logic        oam_write,
    output logic [7:0]  oam_data,
    output logic        dma_active
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  t;
    logic [7:0]  src_hi;
    logic [7:0]  index;
    logic [7:0]  data_latch;
    logic        restart;
    logic        pending;

    logic        ff46_sel;
    logic        ff46_write;
    logic        dma_bus;
    logic        blocked;
    logic [7:0]  src_eff;

    // T-cycle phase; stays in lockstep with the CPU since both leave reset together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t <= 2'd0;
        end else begin
            t <= t + 2'd1;
        end
    end

    // Register writes land at T2; all state changes wait for the M-cycle boundary at T3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            src_hi     <= 8'hFF;
            index      <= 8'd0;
            data_latch <= 8'd0;
            restart    <= 1'b0;
            pending    <= 1'b0;
        end else begin
            if (t == 2'd2 && ff46_write) begin
                src_hi  <= cpu_data_out;
                pending <= 1'b1;
            end
            if (t == 2'd2 && state == ACTIVE) begin
                data_latch <= bus_data_in;
            end
            if (t == 2'd3) begin
                if (pending) begin
                    state   <= START;
                    index   <= 8'd0;
                    restart <= (state == ACTIVE) || restart;
                    pending <= 1'b0;
                end else begin
                    case (state)
                        START: begin
                            state <= ACTIVE;
                        end
                        ACTIVE: begin
                            if (index == 8'd159) begin
                                state   <= IDLE;
                                index   <= 8'd0;
                                restart <= 1'b0;
                            end else begin
                                index <= index + 8'd1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        ff46_sel   = (cpu_addr == 16'hFF46);
        ff46_write = cpu_enable & cpu_write & ff46_sel;
        // 0xE0-0xFF pages mirror work RAM at 0xC0-0xDF.
        src_eff    = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
        dma_active = (state == ACTIVE) | ((state == START) & restart);
        dma_bus    = (state == ACTIVE) && (t == 2'd1);
        blocked    = dma_active && (cpu_addr < 16'hFF00);
    end

    // The DMA owns the bus only in T1 of an active M-cycle; the CPU strobes only in T2.
    always_comb begin
        bus_addr     = dma_bus ? {src_eff, index} : cpu_addr;
        bus_write    = dma_bus ? 1'b0 : cpu_write;
        bus_data_out = cpu_data_out;
        bus_enable   = dma_bus | (cpu_enable & ~blocked & ~ff46_sel);
        if (ff46_sel) begin
            cpu_data_in = src_hi;
        end else if (blocked) begin
            cpu_data_in = 8'hFF;
        end else begin
            cpu_data_in = bus_data_in;
        end
    end

    always_comb begin
        oam_write = (state == ACTIVE) && (t == 2'd3);
        oam_addr  = index;
        oam_data  = data_latch;
    end

endmodule
